// File: rtl/gamma_lut_loader_if.sv
// Byte-packet bus carrying a full gamma table from the loader into gamma_correction.
// The loader drives it through the master modport; gamma_correction listens on slave.
interface gamma_lut_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              SOP;
    logic              EOP;
    logic              VLD;
    logic [DATA_W-1:0] packet_data;

    modport master (output SOP, EOP, VLD, packet_data);
    modport slave  (input  SOP, EOP, VLD, packet_data);
endinterface

// File: rtl/gamma_lut_loader.sv
// Buffers host writes in a shadow gamma table and streams it to gamma_correction as one
// SOP..EOP packet, only inside an inter-frame gap of the monitored video stream.
module gamma_lut_loader #(
    parameter int unsigned NROWS     = 512,
    parameter int unsigned LUT_DEPTH = 256,
    parameter int unsigned DATA_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               load_req,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    gamma_lut_loader_if.master pkt,
    output logic               video_hold,
    output logic               busy,
    output logic               load_done,
    output logic               lut_valid,
    output logic               cmd_err,
    output logic               frame_err
);

    localparam int unsigned AddrW = $clog2(LUT_DEPTH);
    localparam int unsigned RowW  = (NROWS > 1) ? $clog2(NROWS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitGap,
        StSend,
        StDone
    } state_e;

    state_e            state_q;
    logic [AddrW-1:0]  addr_q;
    logic [RowW-1:0]   row_cnt_q;
    logic              frame_active_q;
    logic [DATA_W-1:0] shadow_q [LUT_DEPTH];

    logic              sof;
    logic              eol;
    logic [RowW-1:0]   row_base;
    logic              last_row;

    assign sof      = s_axis_tvalid & s_axis_tuser;
    assign eol      = s_axis_tvalid & s_axis_tlast;
    // A start-of-frame beat restarts the row count before its own tlast is counted.
    assign row_base = sof ? '0 : row_cnt_q;
    assign last_row = (row_base == RowW'(NROWS - 1));

    // Shadow table has no reset; host must fill it before the first load.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == StIdle)) begin
            shadow_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            row_cnt_q       <= '0;
            frame_active_q  <= 1'b0;
            pkt.SOP         <= 1'b0;
            pkt.EOP         <= 1'b0;
            pkt.VLD         <= 1'b0;
            pkt.packet_data <= '0;
            video_hold      <= 1'b0;
            busy            <= 1'b0;
            load_done       <= 1'b0;
            lut_valid       <= 1'b0;
            cmd_err         <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            // Frame tracker runs regardless of loader state.
            if (sof) begin
                frame_active_q <= 1'b1;
                row_cnt_q      <= '0;
            end
            if (eol) begin
                if (last_row) begin
                    frame_active_q <= 1'b0;
                    row_cnt_q      <= '0;
                end else begin
                    row_cnt_q <= row_base + RowW'(1);
                end
            end

            cmd_err         <= (wr_en | load_req) & (state_q != StIdle);
            load_done       <= 1'b0;
            pkt.SOP         <= 1'b0;
            pkt.EOP         <= 1'b0;
            pkt.VLD         <= 1'b0;
            pkt.packet_data <= '0;

            unique case (state_q)
                StIdle: begin
                    busy       <= load_req;
                    video_hold <= load_req;
                    if (load_req) begin
                        frame_err <= 1'b0;
                        state_q   <= StWaitGap;
                    end
                end
                StWaitGap: begin
                    if (!frame_active_q && !sof) begin
                        addr_q  <= '0;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    pkt.SOP         <= (addr_q == '0);
                    pkt.EOP         <= (addr_q == AddrW'(LUT_DEPTH - 1));
                    pkt.VLD         <= 1'b1;
                    pkt.packet_data <= shadow_q[addr_q];
                    // The packet is never aborted; a frame that sneaks in is only flagged.
                    if (sof) begin
                        frame_err <= 1'b1;
                    end
                    if (addr_q == AddrW'(LUT_DEPTH - 1)) begin
                        state_q <= StDone;
                    end else begin
                        addr_q <= addr_q + AddrW'(1);
                    end
                end
                StDone: begin
                    load_done <= 1'b1;
                    lut_valid <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_lut_loader.sv
// Directed-random bench for gamma_lut_loader: a reference table in an array predicts every
// packet byte; frame timing and error pulses are predicted from the loader's stated rules.
module tb_gamma_lut_loader;

    localparam int unsigned NROWS = 4;
    localparam int KNone = 0;
    localparam int KWr   = 1;
    localparam int KLd   = 2;
    localparam int KSof  = 3;
    localparam int KRst  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       load_req = 1'b0;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       video_hold;
    logic       busy;
    logic       load_done;
    logic       lut_valid;
    logic       cmd_err;
    logic       frame_err;

    logic [7:0] model [256];
    int         total = 0;
    int         bad = 0;
    bit         seen_vld;
    bit         hold_lost;

    gamma_lut_loader_if #(.DATA_W(8)) pkt ();

    gamma_lut_loader #(
        .NROWS(NROWS),
        .LUT_DEPTH(256),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .load_req(load_req),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast),
        .pkt(pkt),
        .video_hold(video_hold),
        .busy(busy),
        .load_done(load_done),
        .lut_valid(lut_valid),
        .cmd_err(cmd_err),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_table(input bit pattern);
        for (int i = 0; i < 256; i++) begin
            wr_en   = 1'b1;
            wr_addr = 8'(i);
            wr_data = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
            model[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic issue_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_row(input bit sof, input bit req, input bit watch);
        int len;
        len = int'($urandom_range(4, 2));
        for (int p = 0; p < len; p++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = sof && (p == 0);
            s_axis_tlast  = (p == len - 1);
            load_req      = req && (p == 0);
            tick();
            load_req = 1'b0;
            if (watch) begin
                if (pkt.VLD) seen_vld = 1'b1;
                if (!video_hold) hold_lost = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_sop(input int start, output int lat);
        lat = start;
        while (!pkt.SOP && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Walks one packet from its SOP cycle, optionally injecting a disturbance at byte `at`.
    task automatic collect(input int kind, input int at, output int n);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            if (!pkt.VLD) break;
            chk("packet_byte", {pkt.SOP, pkt.EOP, pkt.packet_data},
                {(n == 0), (n == 255), (n < 256) ? model[n] : 8'h00});
            if (n == at) begin
                case (kind)
                    KWr: begin
                        wr_en   = 1'b1;
                        wr_addr = 8'd7;
                        wr_data = ~model[7];
                    end
                    KLd: load_req = 1'b1;
                    KSof: begin
                        s_axis_tvalid = 1'b1;
                        s_axis_tuser  = 1'b1;
                    end
                    KRst: begin
                        rst = 1'b0;
                        #1;
                        chk("rst_mid_pkt", {pkt.SOP, pkt.VLD, pkt.EOP}, 0);
                        chk("rst_mid_busy", busy, 0);
                        chk("rst_mid_lut_valid", lut_valid, 0);
                        return;
                    end
                    default: ;
                endcase
            end
            tick();
            wr_en         = 1'b0;
            load_req      = 1'b0;
            s_axis_tvalid = 1'b0;
            s_axis_tuser  = 1'b0;
            if (n == at) begin
                case (kind)
                    KWr:     chk("cmd_err_on_write", cmd_err, 1);
                    KLd:     chk("cmd_err_on_load", cmd_err, 1);
                    KSof:    chk("frame_err_set", frame_err, 1);
                    default: ;
                endcase
            end
            n++;
        end
        chk("load_done_pulse", load_done, 1);
        chk("lut_valid_set", lut_valid, 1);
    endtask

    task automatic post_done();
        tick();
        chk("busy_cleared", busy, 0);
        chk("hold_cleared", video_hold, 0);
        chk("load_done_single", load_done, 0);
    endtask

    initial begin
        int lat;
        int n;

        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pkt", {pkt.SOP, pkt.EOP, pkt.VLD, pkt.packet_data}, 0);
        chk("reset_ctl", {video_hold, busy, load_done, lut_valid, cmd_err, frame_err}, 0);
        rst = 1'b1;
        tick();

        // Idle stream: fixed pattern, latency 3 to SOP, full packet.
        fill_table(1'b1);
        issue_load();
        chk("busy_after_req", busy, 1);
        chk("hold_after_req", video_hold, 1);
        wait_sop(1, lat);
        chk("sop_latency", lat, 3);
        collect(KNone, -1, n);
        chk("idle_pkt_len", n, 256);
        post_done();

        // Request mid-frame: packet waits for the frame's last tlast.
        fill_table(1'b0);
        seen_vld  = 1'b0;
        hold_lost = 1'b0;
        send_row(1'b1, 1'b0, 1'b0);
        send_row(1'b0, 1'b0, 1'b0);
        send_row(1'b0, 1'b1, 1'b1);
        send_row(1'b0, 1'b0, 1'b1);
        chk("no_vld_in_frame", seen_vld, 0);
        chk("hold_in_frame", hold_lost, 0);
        wait_sop(0, lat);
        chk("sop_after_frame", lat, 2);
        collect(KNone, -1, n);
        chk("frame_pkt_len", n, 256);
        post_done();

        // Same-cycle write+load lands first; a write during SEND is dropped.
        wr_en    = 1'b1;
        wr_addr  = 8'($urandom);
        wr_data  = 8'($urandom);
        model[wr_addr] = wr_data;
        load_req = 1'b1;
        tick();
        wr_en    = 1'b0;
        load_req = 1'b0;
        wait_sop(1, lat);
        chk("sop_latency_wr", lat, 3);
        collect(KWr, 3, n);
        chk("wr_pkt_len", n, 256);
        post_done();
        issue_load();
        wait_sop(1, lat);
        collect(KNone, -1, n);
        chk("old_shadow_pkt_len", n, 256);
        post_done();

        // Load request during SEND is rejected and not queued.
        issue_load();
        wait_sop(1, lat);
        collect(KLd, 20, n);
        chk("ld_pkt_len", n, 256);
        post_done();
        seen_vld = 1'b0;
        repeat (20) begin
            tick();
            if (pkt.VLD) seen_vld = 1'b1;
        end
        chk("no_second_packet", seen_vld, 0);
        chk("idle_after_reject", busy, 0);

        // Frame start during SEND: sticky frame_err, packet completes.
        issue_load();
        wait_sop(1, lat);
        collect(KSof, 100, n);
        chk("sof_pkt_len", n, 256);
        chk("frame_err_end", frame_err, 1);
        post_done();
        chk("frame_err_sticky", frame_err, 1);
        issue_load();
        chk("frame_err_cleared", frame_err, 0);
        seen_vld  = 1'b0;
        hold_lost = 1'b0;
        repeat (NROWS) send_row(1'b0, 1'b0, 1'b1);
        chk("no_vld_rest_frame", seen_vld, 0);
        chk("hold_rest_frame", hold_lost, 0);
        wait_sop(0, lat);
        chk("sop_after_rest_frame", lat, 2);
        collect(KNone, -1, n);
        chk("post_err_pkt_len", n, 256);
        post_done();

        // Reset at byte 50 truncates; a fresh load restarts from SOP.
        issue_load();
        wait_sop(1, lat);
        collect(KRst, 50, n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("lut_valid_after_rst", lut_valid, 0);
        fill_table(1'b0);
        issue_load();
        wait_sop(1, lat);
        chk("sop_latency_rst", lat, 3);
        collect(KNone, -1, n);
        chk("reload_pkt_len", n, 256);
        post_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
